ms_xfer_ctrl: RTL and testbench

Sequencer and arbiter for the team's two-stage master/slave register. It shares one WIDTH-bit master/slave register between two requesters. Arbitration is round-robin, and each granted word moves through a capture phase (phi1), a non-overlap gap, a transfer phase (phi2) and a second gap. It is single-clock, and phi1/phi2 are clock-enable strobes, never clocks.

---
 rtl/ms_xfer_pkg.sv | 21 ++
 rtl/ms_stage_reg.sv | 32 +++
 rtl/ms_xfer_ctrl.sv | 112 +++++++++++
 tb/tb_ms_xfer_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ms_xfer_pkg.sv
// rtl/ms_xfer_pkg.sv - shared types and constants for the master/slave transfer controller
package ms_xfer_pkg;

    localparam int GAP_W = 4;

    typedef logic id_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_GAP_A,
        ST_TRANSFER,
        ST_GAP_B,
        ST_DONE
    } state_t;

    function automatic logic [1:0] id_onehot(input id_t id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ms_stage_reg.sv
// rtl/ms_stage_reg.sv - two-stage master/slave register with capture and transfer enables
module ms_stage_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cap_en,
    input  logic             xfer_en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] master_q;
    logic [WIDTH-1:0] slave_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            master_q <= '0;
            slave_q  <= '0;
        end else begin
            if (cap_en) begin
                master_q <= d;
            end
            if (xfer_en) begin
                slave_q <= master_q;
            end
        end
    end

    assign q = slave_q;

endmodule

// File: rtl/ms_xfer_ctrl.sv
// rtl/ms_xfer_ctrl.sv - round-robin sequencer sharing one master/slave register between two requesters
module ms_xfer_ctrl
    import ms_xfer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic             phi1,
    output logic             phi2,
    output logic [WIDTH-1:0] q,
    output logic             done,
    output logic             done_id
);

    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP == 0) ? '0 : GAP_W'(GAP - 1);

    state_t            state_q, state_d;
    id_t               id_q, id_d;
    logic [GAP_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  stage_d;

    // id_q doubles as last_id: it holds the granted index for the whole transaction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            id_q    <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    id_d    = (req == 2'b11) ? ~id_q : id_t'(req[1]);
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (GAP == 0) begin
                    state_d = ST_TRANSFER;
                end else begin
                    state_d = ST_GAP_A;
                    cnt_d   = GAP_LOAD;
                end
            end
            ST_GAP_A: begin
                if (cnt_q == '0) begin
                    state_d = ST_TRANSFER;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_TRANSFER: begin
                if (GAP == 0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_GAP_B;
                    cnt_d   = GAP_LOAD;
                end
            end
            ST_GAP_B: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy    = (state_q != ST_IDLE);
    assign phi1    = (state_q == ST_CAPTURE);
    assign phi2    = (state_q == ST_TRANSFER);
    assign done    = (state_q == ST_DONE);
    assign done_id = done & id_q;
    assign gnt     = busy ? id_onehot(id_q) : 2'b00;

    assign stage_d = gnt[1] ? d1 : d0;

    ms_stage_reg #(
        .WIDTH (WIDTH)
    ) u_stage (
        .clk     (clk),
        .reset   (reset),
        .cap_en  (phi1),
        .xfer_en (phi2),
        .d       (stage_d),
        .q       (q)
    );

endmodule

// File: tb/tb_ms_xfer_ctrl.sv
// tb/tb_ms_xfer_ctrl.sv - self-checking bench for ms_xfer_ctrl with GAP=2 and GAP=0 instances
module tb_ms_xfer_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_v [2];
    logic [1:0] reqv  [2];
    logic [7:0] dz0   [2];
    logic [7:0] dz1   [2];

    logic [1:0] o_gnt  [2];
    logic       o_busy [2];
    logic       o_phi1 [2];
    logic       o_phi2 [2];
    logic [7:0] o_q    [2];
    logic       o_done [2];
    logic       o_did  [2];

    ms_xfer_ctrl #(.WIDTH(8), .GAP(2)) u_gap2 (
        .clk(clk), .reset(rst_v[0]), .req(reqv[0]), .d0(dz0[0]), .d1(dz1[0]),
        .gnt(o_gnt[0]), .busy(o_busy[0]), .phi1(o_phi1[0]), .phi2(o_phi2[0]),
        .q(o_q[0]), .done(o_done[0]), .done_id(o_did[0])
    );

    ms_xfer_ctrl #(.WIDTH(8), .GAP(0)) u_gap0 (
        .clk(clk), .reset(rst_v[1]), .req(reqv[1]), .d0(dz0[1]), .d1(dz1[1]),
        .gnt(o_gnt[1]), .busy(o_busy[1]), .phi1(o_phi1[1]), .phi2(o_phi2[1]),
        .q(o_q[1]), .done(o_done[1]), .done_id(o_did[1])
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int gap_of(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    // Model: m_t is the 1-based cycle number inside a transaction (0 = idle)
    int         m_t   [2] = '{0, 0};
    logic       m_id  [2] = '{1'b1, 1'b1};
    logic [7:0] m_cap [2] = '{8'h00, 8'h00};
    logic [7:0] m_q   [2] = '{8'h00, 8'h00};

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst_v[k]) begin
                m_t[k]   <= 0;
                m_id[k]  <= 1'b1;
                m_cap[k] <= 8'h00;
                m_q[k]   <= 8'h00;
            end else if (m_t[k] != 0) begin
                if (m_t[k] == 1) m_cap[k] <= m_id[k] ? dz1[k] : dz0[k];
                if (m_t[k] == gap_of(k) + 2) m_q[k] <= m_cap[k];
                m_t[k] <= (m_t[k] == 2 * gap_of(k) + 3) ? 0 : m_t[k] + 1;
            end else if (reqv[k] != 2'b00) begin
                m_id[k] <= (reqv[k] == 2'b11) ? ~m_id[k] : reqv[k][1];
                m_t[k]  <= 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic       e_busy, e_phi1, e_phi2, e_done, e_did;
            logic [1:0] e_gnt;
            logic [7:0] e_q;
            string      tag;
            tag = $sformatf("g%0d", gap_of(k));
            if (rst_v[k]) begin
                e_busy = 0; e_phi1 = 0; e_phi2 = 0; e_done = 0; e_did = 0; e_gnt = 2'b00; e_q = 8'h00;
            end else begin
                e_busy = (m_t[k] != 0);
                e_phi1 = (m_t[k] == 1);
                e_phi2 = (m_t[k] == gap_of(k) + 2);
                e_done = (m_t[k] == 2 * gap_of(k) + 3);
                e_did  = e_done ? m_id[k] : 1'b0;
                e_gnt  = e_busy ? (m_id[k] ? 2'b10 : 2'b01) : 2'b00;
                e_q    = m_q[k];
            end
            check({tag, "_busy"},    32'(o_busy[k]), 32'(e_busy));
            check({tag, "_phi1"},    32'(o_phi1[k]), 32'(e_phi1));
            check({tag, "_phi2"},    32'(o_phi2[k]), 32'(e_phi2));
            check({tag, "_done"},    32'(o_done[k]), 32'(e_done));
            check({tag, "_done_id"}, 32'(o_did[k]),  32'(e_did));
            check({tag, "_gnt"},     32'(o_gnt[k]),  32'(e_gnt));
            check({tag, "_q"},       32'(o_q[k]),    32'(e_q));
            check({tag, "_phi_overlap"}, 32'(o_phi1[k] & o_phi2[k]), 32'd0);
        end
    end

    task automatic wait_done(input int k, input int budget, output int waited);
        logic ok;
        ok = 1'b0;
        waited = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            waited++;
            if (o_done[k]) begin
                ok = 1'b1;
                break;
            end
        end
        check("done_timeout", 32'(ok), 32'd1);
    endtask

    task automatic edge_then_drive();
        @(posedge clk);
        #2;
    endtask

    logic       ph1_h [1:8];
    logic       ph2_h [1:8];
    logic       dn_h  [1:8];
    logic       did_h [1:8];
    logic       bz_h  [1:8];
    logic [7:0] q_h   [1:8];

    initial begin
        int waited;
        int busy_cnt;
        int done_cnt;
        for (int k = 0; k < 2; k++) begin
            rst_v[k] = 1'b1; reqv[k] = 2'b00; dz0[k] = 8'h00; dz1[k] = 8'h00;
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(o_busy[0]), 32'd0);
        check("rst_q",    32'(o_q[0]),    32'h00);
        edge_then_drive();
        rst_v[0] = 1'b0;
        rst_v[1] = 1'b0;
        @(negedge clk);
        check("idle_gnt",  32'(o_gnt[0]),  32'd0);
        check("idle_done", 32'(o_done[0]), 32'd0);

        // contention out of reset: 0, then 1, then 0
        edge_then_drive();
        reqv[0] = 2'b11; dz0[0] = 8'h11; dz1[0] = 8'h22;
        wait_done(0, 20, waited);
        check("cont1_id", 32'(o_did[0]), 32'd0);
        check("cont1_q",  32'(o_q[0]),   32'h11);
        wait_done(0, 20, waited);
        check("cont2_id",      32'(o_did[0]), 32'd1);
        check("cont2_q",       32'(o_q[0]),   32'h22);
        check("cont2_spacing", 32'(waited),   32'd8);
        wait_done(0, 20, waited);
        check("cont3_id", 32'(o_did[0]), 32'd0);
        check("cont3_q",  32'(o_q[0]),   32'h11);
        reqv[0] = 2'b00;
        repeat (3) edge_then_drive();

        // single request, cycle-by-cycle
        reqv[0] = 2'b01; dz0[0] = 8'hA5;
        edge_then_drive();
        reqv[0] = 2'b00;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            ph1_h[c] = o_phi1[0]; ph2_h[c] = o_phi2[0]; dn_h[c] = o_done[0];
            did_h[c] = o_did[0];  bz_h[c]  = o_busy[0]; q_h[c]  = o_q[0];
        end
        check("single_phi1_c1", 32'(ph1_h[1]), 32'd1);
        check("single_phi2_c4", 32'(ph2_h[4]), 32'd1);
        check("single_q_c4",    32'(q_h[4]),   32'h11);
        check("single_q_c5",    32'(q_h[5]),   32'hA5);
        check("single_done_c7", 32'(dn_h[7]),  32'd1);
        check("single_id_c7",   32'(did_h[7]), 32'd0);
        check("single_busy_c7", 32'(bz_h[7]),  32'd1);
        check("single_busy_c8", 32'(bz_h[8]),  32'd0);
        check("model_q_pin",    32'(m_q[0]),   32'hA5);

        // data hold: change during GAP_A ignored
        edge_then_drive();
        reqv[0] = 2'b01; dz0[0] = 8'h3C;
        edge_then_drive();
        reqv[0] = 2'b00;
        edge_then_drive();
        dz0[0] = 8'hFF;
        wait_done(0, 20, waited);
        check("hold_gapa_q", 32'(o_q[0]), 32'h3C);

        // change during CAPTURE, held through the sampling edge
        edge_then_drive();
        reqv[0] = 2'b01; dz0[0] = 8'h00;
        edge_then_drive();
        dz0[0] = 8'hC3; reqv[0] = 2'b00;
        wait_done(0, 20, waited);
        check("hold_cap_q", 32'(o_q[0]), 32'hC3);

        // request withdrawn after one cycle
        edge_then_drive();
        reqv[0] = 2'b01;
        edge_then_drive();
        reqv[0] = 2'b00;
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            busy_cnt += int'(o_busy[0]);
            done_cnt += int'(o_done[0]);
        end
        check("wd_busy_cycles", 32'(busy_cnt),  32'd7);
        check("wd_done_pulses", 32'(done_cnt),  32'd1);
        check("wd_idle_after",  32'(o_busy[0]), 32'd0);

        // reset during GAP_B of 8'h77
        edge_then_drive();
        reqv[0] = 2'b01; dz0[0] = 8'h77;
        edge_then_drive();
        reqv[0] = 2'b00;
        repeat (3) @(posedge clk);
        @(posedge clk);
        #1;
        check("gapb_q_before", 32'(o_q[0]),    32'h77);
        check("gapb_busy",     32'(o_busy[0]), 32'd1);
        #1;
        rst_v[0] = 1'b1;
        #1;
        check("arst_q",    32'(o_q[0]),    32'h00);
        check("arst_gnt",  32'(o_gnt[0]),  32'd0);
        check("arst_busy", 32'(o_busy[0]), 32'd0);
        check("arst_phi",  32'({o_phi1[0], o_phi2[0]}), 32'd0);
        check("arst_done", 32'(o_done[0]), 32'd0);
        edge_then_drive();
        rst_v[0] = 1'b0;
        edge_then_drive();
        reqv[0] = 2'b11; dz0[0] = 8'h01; dz1[0] = 8'h02;
        wait_done(0, 20, waited);
        reqv[0] = 2'b00;
        check("post_rst_id", 32'(o_did[0]), 32'd0);
        check("post_rst_q",  32'(o_q[0]),   32'h01);

        // GAP=0 build
        repeat (2) edge_then_drive();
        reqv[1] = 2'b10; dz1[1] = 8'h5A;
        edge_then_drive();
        reqv[1] = 2'b00;
        @(negedge clk);
        check("g0_c1_phi1", 32'(o_phi1[1]), 32'd1);
        @(negedge clk);
        check("g0_c2_phi2", 32'(o_phi2[1]), 32'd1);
        check("g0_c2_q",    32'(o_q[1]),    32'h00);
        @(negedge clk);
        check("g0_c3_done", 32'(o_done[1]), 32'd1);
        check("g0_c3_id",   32'(o_did[1]),  32'd1);
        check("g0_c3_q",    32'(o_q[1]),    32'h5A);
        @(negedge clk);
        check("g0_c4_busy", 32'(o_busy[1]), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
